// File: rtl/memory_arbiter.sv
// memory_arbiter: one-at-a-time arbiter putting icache/dcache traffic onto a shared RAM port
// Ports: CLK/RST (sync active-high); icache iREN/iaddr -> iwait/iload; dcache dREN/dWEN/daddr/dstore -> dwait/dload;
// RAM side ramREN/ramWEN/ramaddr/ramstore/ramerr out, ramload/ramstate in (00 FREE, 01 BUSY, 10 ACCESS, 11 ERROR).
// Optional MEMARB_STARVE_GUARD_EN: after STARVE_LIMIT dcache grants with iREN pending, the icache is served first.
module memory_arbiter #(
  parameter int ADDR_W = 32,
`ifdef MEMARB_STARVE_GUARD_EN
  parameter int STARVE_LIMIT = 4,
`endif
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              iREN,
  input  logic [ADDR_W-1:0] iaddr,
  output logic              iwait,
  output logic [DATA_W-1:0] iload,
  input  logic              dREN,
  input  logic              dWEN,
  input  logic [ADDR_W-1:0] daddr,
  input  logic [DATA_W-1:0] dstore,
  output logic              dwait,
  output logic [DATA_W-1:0] dload,
  output logic              ramREN,
  output logic              ramWEN,
  output logic [ADDR_W-1:0] ramaddr,
  output logic [DATA_W-1:0] ramstore,
  input  logic [DATA_W-1:0] ramload,
  input  logic [1:0]        ramstate,
  output logic              ramerr
);
  typedef enum logic [1:0] {IDLE, IACC, DRD, DWR} state_t;
  state_t state_q, state_d;
  logic req, done, icmp, dcmp, starve;
  // req is the owner still asserting its own request; losing it means abort
  assign req  = state_q == IACC ? iREN : state_q == DRD ? dREN : state_q == DWR ? dWEN : 1'b0;
  assign done = req && ramstate == 2'b10;
  assign icmp = done && state_q == IACC;
  assign dcmp = done && state_q != IACC;
  assign iwait = !icmp;
  assign dwait = !dcmp;
  assign iload = ramload;
  assign dload = ramload;
  assign ramREN = state_q == IACC || state_q == DRD;
  assign ramWEN = state_q == DWR;
  assign ramaddr = state_q == IACC ? iaddr : state_q == IDLE ? '0 : daddr;
  assign ramstore = state_q == DWR ? dstore : '0;
  assign ramerr = state_q != IDLE && ramstate == 2'b11;
`ifdef MEMARB_STARVE_GUARD_EN
  localparam int CW = $clog2(STARVE_LIMIT + 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign starve = iREN && cnt_q == CW'(STARVE_LIMIT);
  always_comb
    cnt_d = (state_q == IDLE && !iREN) || icmp ? '0 :
            dcmp && iREN && cnt_q != CW'(STARVE_LIMIT) ? cnt_q + 1'b1 : cnt_q;
  always_ff @(posedge CLK)
    cnt_q <= RST ? '0 : cnt_d;
`else
  assign starve = 1'b0;
`endif
  always_comb
    state_d = state_q == IDLE ? (starve ? IACC : dWEN ? DWR : dREN ? DRD : iREN ? IACC : IDLE) :
              !req || done ? IDLE : state_q;
  always_ff @(posedge CLK)
    state_q <= RST ? IDLE : state_d;
endmodule
